// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit.
// Optional extended opcodes are enabled with LEGV8_EXT_OPS_EN (see legv8_op_classify).
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    C_LD,
    C_ST,
    C_CBZ,
    C_RTYPE,
    C_IMM,
    C_CBNZ,
    C_B,
    C_ILLEGAL
  } cls_t;

  // Opcode patterns on instruction[31:21]; '?' bits are don't-care in casez
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;
  localparam logic [10:0] OP_ADDS = 11'b1?001011000;
  localparam logic [10:0] OP_LOGR = 11'b10?01010000;
  localparam logic [10:0] OP_ADDI = 11'b1001000100?;
  localparam logic [10:0] OP_SUBI = 11'b1101000100?;
  localparam logic [10:0] OP_CBNZ = 11'b10110101???;
  localparam logic [10:0] OP_B    = 11'b000101?????;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/legv8_op_classify.sv
// Combinational opcode classifier: 11-bit opcode -> instruction class.
// ADDI/SUBI, CBNZ and B are recognised only when LEGV8_EXT_OPS_EN is defined;
// otherwise they fall through to C_ILLEGAL.
module legv8_op_classify
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] op,
  output cls_t        cls
);

  // Pattern match; anything unmatched is illegal
  always_comb begin
    cls = C_ILLEGAL;
    casez (op)
      OP_LDUR: cls = C_LD;
      OP_STUR: cls = C_ST;
      OP_CBZ:  cls = C_CBZ;
      OP_ADDS: cls = C_RTYPE;
      OP_LOGR: cls = C_RTYPE;
`ifdef LEGV8_EXT_OPS_EN
      OP_ADDI: cls = C_IMM;
      OP_SUBI: cls = C_IMM;
      OP_CBNZ: cls = C_CBNZ;
      OP_B:    cls = C_B;
`endif
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/legv8_mc_control.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory-wait timeout and a retired-instruction counter.
// Optional macro LEGV8_EXT_OPS_EN adds ADDI/SUBI, CBNZ and B support.
//
// state    | meaning
// S_FETCH  | instr_ready high, waiting for instr_valid to latch Op
// S_DECODE | classify latched opcode; illegal/B skip straight to WB
// S_EXEC   | ALU controls for the class; LD/ST continue to MEM
// S_MEM    | hold MemRead/MemWrite until mem_ready or timeout
// S_WB     | one-cycle retire: PCWrite, RegWrite/branch/error pulses
module legv8_mc_control
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [10:0]         Op,
  input  logic                mem_ready,
  output logic                Reg2Loc,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                Branch,
  output logic [1:0]          ALUOp,
  output logic                BranchNZ,
  output logic                UncondBranch,
  output logic                PCWrite,
  output logic                illegal,
  output logic                mem_err,
  output logic [RETIRE_W-1:0] instret
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  logic [10:0]       op_q;
  logic [WCNT_W-1:0] wcnt;
  logic              tout_q;
  cls_t              cls;

  legv8_op_classify u_classify (
    .op  (op_q),
    .cls (cls)
  );

  // Sequencer, memory wait counter and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      op_q    <= '0;
      wcnt    <= '0;
      tout_q  <= 1'b0;
      instret <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            op_q  <= Op;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (cls == C_ILLEGAL || cls == C_B) state <= S_WB;
          else                                state <= S_EXEC;
        end
        S_EXEC: begin
          if (cls == C_LD || cls == C_ST) state <= S_MEM;
          else                            state <= S_WB;
        end
        S_MEM: begin
          // mem_ready on the last allowed cycle still counts as a normal completion
          if (mem_ready) begin
            state <= S_WB;
          end else if (wcnt == WCNT_LAST) begin
            state  <= S_WB;
            tout_q <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        S_WB: begin
          if (cls != C_ILLEGAL && !tout_q) instret <= instret + RETIRE_W'(1);
          wcnt   <= '0;
          tout_q <= 1'b0;
          state  <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode from state, latched opcode class and timeout flag
  always_comb begin
    instr_ready  = 1'b0;
    Reg2Loc      = 1'b0;
    ALUSrc       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Branch       = 1'b0;
    ALUOp        = ALUOP_ADD;
    BranchNZ     = 1'b0;
    UncondBranch = 1'b0;
    PCWrite      = 1'b0;
    illegal      = 1'b0;
    mem_err      = 1'b0;
    case (state)
      S_FETCH: instr_ready = 1'b1;
      S_EXEC: begin
        case (cls)
          C_LD: ALUSrc = 1'b1;
          C_ST: begin
            ALUSrc  = 1'b1;
            Reg2Loc = 1'b1;
          end
          C_RTYPE: ALUOp = ALUOP_FUNCT;
          C_IMM: begin
            ALUSrc = 1'b1;
            ALUOp  = ALUOP_FUNCT;
          end
          C_CBZ, C_CBNZ: begin
            Reg2Loc = 1'b1;
            ALUOp   = ALUOP_PASSB;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        MemRead  = (cls == C_LD);
        MemWrite = (cls == C_ST);
      end
      S_WB: begin
        PCWrite  = 1'b1;
        RegWrite = !tout_q && (cls == C_LD || cls == C_RTYPE || cls == C_IMM);
        MemtoReg = !tout_q && (cls == C_LD);
        Branch   = (cls == C_CBZ);
`ifdef LEGV8_EXT_OPS_EN
        BranchNZ     = (cls == C_CBNZ);
        UncondBranch = (cls == C_B);
`endif
        illegal  = (cls == C_ILLEGAL);
        mem_err  = tout_q;
      end
      default: ;
    endcase
  end

endmodule
